pll_cfg_ctrl: RTL and testbench

Controller and sequencer that drives the iCE40 two-output PLL core's control side: RESETB, BYPASS, DYNAMICDELAY and the SCLK/SDI/SDO serial configuration port. It filters LOCK and produces a clean active-low system reset for logic clocked by the PLL outputs. It also accepts reconfiguration requests over a valid/ready handshake. It runs on the PLL reference clock, never on a PLL output.

---
 rtl/pll_cfg_pkg.sv | 19 +
 rtl/pll_cfg_ctrl_if.sv | 30 +++
 rtl/pll_cfg_shifter.sv | 101 ++++++++++
 rtl/pll_cfg_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pll_cfg_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_cfg_pkg.sv
// Shared types and helpers for the iCE40 PLL configuration controller.
package pll_cfg_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        LOCKED    = 2'd2,
        SHIFT     = 2'd3
    } pll_state_e;

    // Depth of the LOCK synchronizer chain.
    localparam int SYNC_STAGES = 2;

    // Width needed for a counter that must be able to hold max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pll_cfg_ctrl_if.sv
// Reconfiguration request channel: valid/ready handshake plus read-back word.
interface pll_cfg_ctrl_if
    import pll_cfg_pkg::*;
#(
    parameter int CFG_W = 8
);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [7:0]       cfg_delay;
    logic [CFG_W-1:0] cfg_word;
    logic [CFG_W-1:0] rd_word;

    modport master (
        output cfg_valid,
        output cfg_delay,
        output cfg_word,
        input  cfg_ready,
        input  rd_word
    );

    modport slave (
        input  cfg_valid,
        input  cfg_delay,
        input  cfg_word,
        output cfg_ready,
        output rd_word
    );

endinterface

// File: rtl/pll_cfg_shifter.sv
// Serial engine for the PLL configuration port: shifts tx_word out MSB first on
// sdi while capturing sdo into rx_word, one bit per 2*SCLK_DIV clk cycles.
module pll_cfg_shifter
    import pll_cfg_pkg::*;
#(
    parameter int CFG_W    = 8,
    parameter int SCLK_DIV = 2
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CFG_W-1:0] tx_word,
    output logic             busy,
    output logic             done,
    output logic [CFG_W-1:0] rx_word,
    output logic             sclk,
    output logic             sdi,
    input  logic             sdo
);

    localparam int PH_W  = cnt_width(2 * SCLK_DIV);
    localparam int BIT_W = cnt_width(CFG_W);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * SCLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_W - 1);

    logic             busy_q,  busy_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [BIT_W-1:0] bit_q,   bit_d;
    logic [CFG_W-1:0] sh_q,    sh_d;
    logic [CFG_W-1:0] rx_q,    rx_d;
    logic             sclk_q,  sclk_d;
    logic             last_phase;
    logic             last_bit;

    assign last_phase = (phase_q == PH_LAST);
    assign last_bit   = (bit_q == BIT_LAST);
    assign done       = busy_q && last_phase && last_bit;
    assign busy       = busy_q;
    assign rx_word    = rx_q;
    assign sclk       = sclk_q;
    assign sdi        = sh_q[CFG_W-1];

    // Bit/phase sequencing: sclk low for the first half of each bit, sdo
    // captured on the edge where sclk rises, word shifts at the end of a bit.
    always_comb begin
        busy_d  = busy_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        if (start && !busy_q) begin
            busy_d  = 1'b1;
            phase_d = '0;
            bit_d   = '0;
            sh_d    = tx_word;
            sclk_d  = 1'b0;
        end else if (busy_q) begin
            if (last_phase) begin
                phase_d = '0;
                sh_d    = sh_q << 1;
                sclk_d  = 1'b0;
                if (last_bit) begin
                    busy_d = 1'b0;
                    bit_d  = '0;
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end else begin
                phase_d = phase_q + PH_W'(1);
                if (phase_q == PH_RISE) begin
                    sclk_d = 1'b1;
                    rx_d   = rx_q << 1;
                    rx_d[0] = sdo;
                end
            end
        end
    end

    // Shifter registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            phase_q <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
        end
    end

endmodule

// File: rtl/pll_cfg_ctrl.sv
// Sequencer for the iCE40 PLL control side: reset pulse, lock filtering with
// timeout, clean downstream reset, and serial reconfiguration on request.
// Runs on the PLL reference clock only.
module pll_cfg_ctrl
    import pll_cfg_pkg::*;
#(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_FILTER  = 8,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int CFG_W        = 8,
    parameter int SCLK_DIV     = 2
)(
    input  logic       clk,
    input  logic       rst_n,
    pll_cfg_ctrl_if.slave cfg,
    output logic       pll_resetb,
    output logic       pll_bypass,
    output logic [7:0] pll_dynamicdelay,
    output logic       pll_sclk,
    output logic       pll_sdi,
    input  logic       pll_sdo,
    input  logic       pll_lock,
    input  logic       clear_flags,
    output logic       locked,
    output logic       lock_lost,
    output logic       timeout,
    output logic       sys_rst_n
);

    localparam int RST_W  = cnt_width(RESET_CYCLES);
    localparam int FILT_W = cnt_width(LOCK_FILTER);
    localparam int TO_W   = cnt_width(LOCK_TIMEOUT);

    localparam logic [RST_W-1:0]  RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(LOCK_FILTER);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(LOCK_TIMEOUT);

    pll_state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lock_s;

    logic [RST_W-1:0]  rst_cnt_q,  rst_cnt_d;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic [TO_W-1:0]   to_cnt_q,   to_cnt_d;

    logic       resetb_q,    resetb_d;
    logic       locked_q,    locked_d;
    logic       sys_rst_n_q, sys_rst_n_d;
    logic       cfg_ready_q, cfg_ready_d;
    logic [7:0] delay_q,     delay_d;
    logic       lock_lost_q, lock_lost_d;
    logic       timeout_q,   timeout_d;

    logic set_lock_lost;
    logic set_timeout;
    logic start_shift;

    logic             sh_busy;
    logic             sh_done;
    logic [CFG_W-1:0] sh_rx_word;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], pll_lock};
    assign lock_s = sync_q[SYNC_STAGES-1];

    pll_cfg_shifter #(
        .CFG_W    (CFG_W),
        .SCLK_DIV (SCLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_shift),
        .tx_word (cfg.cfg_word),
        .busy    (sh_busy),
        .done    (sh_done),
        .rx_word (sh_rx_word),
        .sclk    (pll_sclk),
        .sdi     (pll_sdi),
        .sdo     (pll_sdo)
    );

    // State register, LOCK synchronizer, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLL_RST;
            sync_q      <= '0;
            rst_cnt_q   <= '0;
            filt_cnt_q  <= '0;
            to_cnt_q    <= '0;
            resetb_q    <= 1'b0;
            locked_q    <= 1'b0;
            sys_rst_n_q <= 1'b0;
            cfg_ready_q <= 1'b0;
            delay_q     <= '0;
            lock_lost_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            rst_cnt_q   <= rst_cnt_d;
            filt_cnt_q  <= filt_cnt_d;
            to_cnt_q    <= to_cnt_d;
            resetb_q    <= resetb_d;
            locked_q    <= locked_d;
            sys_rst_n_q <= sys_rst_n_d;
            cfg_ready_q <= cfg_ready_d;
            delay_q     <= delay_d;
            lock_lost_q <= lock_lost_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state logic and counters; lock beats timeout, lock loss beats a request.
    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = '0;
        filt_cnt_d    = '0;
        to_cnt_d      = '0;
        set_lock_lost = 1'b0;
        set_timeout   = 1'b0;
        start_shift   = 1'b0;
        case (state_q)
            PLL_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    filt_cnt_d = (filt_cnt_q == FILT_MAX) ? filt_cnt_q
                                                          : filt_cnt_q + FILT_W'(1);
                end
                to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TO_W'(1);
                if (filt_cnt_q == FILT_MAX) begin
                    state_d = LOCKED;
                end else if (to_cnt_q == TO_MAX) begin
                    state_d     = PLL_RST;
                    set_timeout = 1'b1;
                end
            end
            LOCKED: begin
                if (!lock_s) begin
                    state_d       = WAIT_LOCK;
                    set_lock_lost = 1'b1;
                end else if (cfg.cfg_valid && cfg_ready_q && !sh_busy) begin
                    state_d     = SHIFT;
                    start_shift = 1'b1;
                end
            end
            SHIFT: begin
                if (sh_done) begin
                    state_d = PLL_RST;
                end
            end
            default: state_d = PLL_RST;
        endcase
    end

    // Registered output values derived from the next state; sticky flags favour set over clear.
    always_comb begin
        resetb_d    = (state_d != PLL_RST);
        locked_d    = (state_d == LOCKED);
        sys_rst_n_d = (state_d == LOCKED);
        cfg_ready_d = (state_d == LOCKED);
        delay_d     = start_shift ? cfg.cfg_delay : delay_q;
        lock_lost_d = set_lock_lost | (lock_lost_q & ~clear_flags);
        timeout_d   = set_timeout | (timeout_q & ~clear_flags);
    end

    assign pll_resetb       = resetb_q;
    assign pll_bypass       = 1'b0;
    assign pll_dynamicdelay = delay_q;
    assign locked           = locked_q;
    assign sys_rst_n        = sys_rst_n_q;
    assign lock_lost        = lock_lost_q;
    assign timeout          = timeout_q;
    assign cfg.cfg_ready    = cfg_ready_q;
    assign cfg.rd_word      = sh_rx_word;

endmodule

// File: tb/tb_pll_cfg_ctrl.sv
// Directed self-checking bench for pll_cfg_ctrl with default parameters.
module tb_pll_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_sdo = 1'b0;
    logic       pll_lock = 1'b0;
    logic       clear_flags = 1'b0;
    logic       pll_resetb;
    logic       pll_bypass;
    logic [7:0] pll_dynamicdelay;
    logic       pll_sclk;
    logic       pll_sdi;
    logic       locked;
    logic       lock_lost;
    logic       timeout;
    logic       sys_rst_n;

    int checks = 0;
    int errors = 0;

    logic [7:0] txPattern;
    logic [7:0] sdoPattern;
    logic       sawResetLow;

    pll_cfg_ctrl_if #(.CFG_W(8)) cfgBus ();

    pll_cfg_ctrl #(
        .RESET_CYCLES (16),
        .LOCK_FILTER  (8),
        .LOCK_TIMEOUT (4096),
        .CFG_W        (8),
        .SCLK_DIV     (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg              (cfgBus),
        .pll_resetb       (pll_resetb),
        .pll_bypass       (pll_bypass),
        .pll_dynamicdelay (pll_dynamicdelay),
        .pll_sclk         (pll_sclk),
        .pll_sdi          (pll_sdi),
        .pll_sdo          (pll_sdo),
        .pll_lock         (pll_lock),
        .clear_flags      (clear_flags),
        .locked           (locked),
        .lock_lost        (lock_lost),
        .timeout          (timeout),
        .sys_rst_n        (sys_rst_n)
    );

    // 10-unit reference clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_resetb"},    32'(pll_resetb),       32'd0);
        checkOutput({pfx, "_bypass"},    32'(pll_bypass),       32'd0);
        checkOutput({pfx, "_delay"},     32'(pll_dynamicdelay), 32'd0);
        checkOutput({pfx, "_sclk"},      32'(pll_sclk),         32'd0);
        checkOutput({pfx, "_sdi"},       32'(pll_sdi),          32'd0);
        checkOutput({pfx, "_rd_word"},   32'(cfgBus.rd_word),   32'd0);
        checkOutput({pfx, "_locked"},    32'(locked),           32'd0);
        checkOutput({pfx, "_sys_rst_n"}, 32'(sys_rst_n),        32'd0);
        checkOutput({pfx, "_lock_lost"}, 32'(lock_lost),        32'd0);
        checkOutput({pfx, "_timeout"},   32'(timeout),          32'd0);
        checkOutput({pfx, "_cfg_ready"}, 32'(cfgBus.cfg_ready), 32'd0);
    endtask

    // Holds reset over two edges and releases it on a falling edge.
    task automatic releaseReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        #1;
        releaseReset();
    endtask

    task automatic applyStimulus(input logic [7:0] delay, input logic [7:0] word);
        cfgBus.cfg_delay = delay;
        cfgBus.cfg_word  = word;
        cfgBus.cfg_valid = 1'b1;
    endtask

    // From a reset release (or PLL_RST entry one edge earlier) with LOCK
    // already synchronized high: resetb low 16 edges, then 8 filter counts
    // plus the registered LOCKED decision, i.e. locked on edge 25.
    task automatic lockSequence(input string pfx);
        tick(15);
        checkOutput({pfx, "_resetb_low15"}, 32'(pll_resetb), 32'd0);
        tick(1);
        checkOutput({pfx, "_resetb_high16"}, 32'(pll_resetb), 32'd1);
        tick(8);
        checkOutput({pfx, "_locked_24"}, 32'(locked), 32'd0);
        tick(1);
        checkOutput({pfx, "_locked_25"}, 32'(locked), 32'd1);
        checkOutput({pfx, "_sys_rst_n_25"}, 32'(sys_rst_n), 32'd1);
        checkOutput({pfx, "_cfg_ready_25"}, 32'(cfgBus.cfg_ready), 32'd1);
    endtask

    initial begin
        cfgBus.cfg_valid = 1'b0;
        cfgBus.cfg_delay = 8'h00;
        cfgBus.cfg_word  = 8'h00;
        txPattern        = 8'hC3;
        sdoPattern       = 8'h96;
        sawResetLow      = 1'b0;

        // Power-on reset values, then lock with pll_lock tied high.
        $display("[TB] reset release with lock tied high");
        pll_lock = 1'b1;
        #2;
        checkResetValues("por");
        releaseReset();
        lockSequence("t1");
        checkOutput("t1_bypass", 32'(pll_bypass), 32'd0);

        // One-cycle LOCK glitch at filter count 5 restarts the filter.
        $display("[TB] lock glitch during filtering");
        applyReset();
        tick(19);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(10);
        checkOutput("t2_locked_30", 32'(locked), 32'd0);
        tick(1);
        checkOutput("t2_locked_31", 32'(locked), 32'd1);
        checkOutput("t2_timeout", 32'(timeout), 32'd0);

        // No lock: timeout after 4096 WAIT_LOCK cycles, new reset pulse, clear.
        $display("[TB] lock timeout");
        pll_lock = 1'b0;
        applyReset();
        tick(16);
        checkOutput("t3_resetb_16", 32'(pll_resetb), 32'd1);
        tick(4096);
        checkOutput("t3_timeout_4112", 32'(timeout), 32'd0);
        tick(1);
        checkOutput("t3_timeout_4113", 32'(timeout), 32'd1);
        checkOutput("t3_resetb_4113", 32'(pll_resetb), 32'd0);
        tick(15);
        checkOutput("t3_resetb_4128", 32'(pll_resetb), 32'd0);
        tick(1);
        checkOutput("t3_resetb_4129", 32'(pll_resetb), 32'd1);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        checkOutput("t3_timeout_cleared", 32'(timeout), 32'd0);

        // Lock loss while LOCKED: sticky flag, no PLL reset, relock.
        $display("[TB] lock loss in LOCKED");
        pll_lock = 1'b1;
        applyReset();
        lockSequence("t4");
        pll_lock = 1'b0;
        tick(2);
        checkOutput("t4_locked_27", 32'(locked), 32'd1);
        tick(1);
        checkOutput("t4_locked_28", 32'(locked), 32'd0);
        checkOutput("t4_lock_lost_28", 32'(lock_lost), 32'd1);
        checkOutput("t4_sys_rst_n_28", 32'(sys_rst_n), 32'd0);
        checkOutput("t4_cfg_ready_28", 32'(cfgBus.cfg_ready), 32'd0);
        sawResetLow = (pll_resetb !== 1'b1);
        for (int i = 29; i <= 55; i++) begin
            tick(1);
            if (pll_resetb !== 1'b1) sawResetLow = 1'b1;
            if (i == 45) pll_lock = 1'b1;
        end
        checkOutput("t4_no_resetb_pulse", 32'(sawResetLow), 32'd0);
        checkOutput("t4_locked_55", 32'(locked), 32'd0);
        tick(1);
        checkOutput("t4_locked_56", 32'(locked), 32'd1);
        checkOutput("t4_lock_lost_sticky", 32'(lock_lost), 32'd1);

        // Reconfiguration: delay 5A, word C3 out, 96 read back from sdo.
        $display("[TB] reconfiguration shift");
        applyStimulus(8'h5A, 8'hC3);
        tick(1);
        cfgBus.cfg_valid = 1'b0;
        checkOutput("t5_locked_start", 32'(locked), 32'd0);
        checkOutput("t5_sys_rst_n_start", 32'(sys_rst_n), 32'd0);
        checkOutput("t5_cfg_ready_start", 32'(cfgBus.cfg_ready), 32'd0);
        checkOutput("t5_delay_start", 32'(pll_dynamicdelay), 32'h5A);
        for (int k = 0; k < 8; k++) begin
            for (int p = 0; p < 4; p++) begin
                if (p == 0) pll_sdo = sdoPattern[7 - k];
                checkOutput($sformatf("t5_sclk_b%0d_p%0d", k, p), 32'(pll_sclk),
                            (p >= 2) ? 32'd1 : 32'd0);
                checkOutput($sformatf("t5_sdi_b%0d_p%0d", k, p), 32'(pll_sdi),
                            32'(txPattern[7 - k]));
                tick(1);
            end
        end
        checkOutput("t5_sclk_end", 32'(pll_sclk), 32'd0);
        checkOutput("t5_resetb_end", 32'(pll_resetb), 32'd0);
        checkOutput("t5_rd_word", 32'(cfgBus.rd_word), 32'h96);
        checkOutput("t5_delay_end", 32'(pll_dynamicdelay), 32'h5A);
        tick(15);
        checkOutput("t5_resetb_low15", 32'(pll_resetb), 32'd0);
        tick(1);
        checkOutput("t5_resetb_high16", 32'(pll_resetb), 32'd1);
        tick(8);
        checkOutput("t5_locked_pre", 32'(locked), 32'd0);
        tick(1);
        checkOutput("t5_relocked", 32'(locked), 32'd1);

        // Asynchronous reset in the middle of a shift (bit 3).
        $display("[TB] reset during shift");
        applyStimulus(8'hA7, 8'h3C);
        tick(1);
        cfgBus.cfg_valid = 1'b0;
        checkOutput("t6_delay_start", 32'(pll_dynamicdelay), 32'hA7);
        tick(12);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("t6");
        releaseReset();
        lockSequence("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
